// File: rtl/hdlc_pkg.sv
// Shared types and line-code constants for the HDLC transmit path.
package hdlc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    END,
    ABORT
  } tx_state_t;

  localparam logic [7:0] HDLC_FLAG      = 8'h7E;
  localparam logic [7:0] HDLC_ABORT     = 8'hFE;
  localparam int         HDLC_STUFF_LEN = 5;

endpackage

// File: rtl/hdlc_zero_insert.sv
// Consecutive-ones tracker for HDLC zero insertion; requests a stuffed 0
// once a full run of payload ones has been emitted.
module hdlc_zero_insert
  import hdlc_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_val,
  input  logic stuff_en,
  output logic stall,
  output logic near_full
);

  logic [2:0] ones_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ones_cnt <= '0;
    end else if (clr || stuff_en) begin
      ones_cnt <= '0;
    end else if (bit_en) begin
      ones_cnt <= bit_val ? ones_cnt + 3'd1 : 3'd0;
    end
  end

  assign stall     = (ones_cnt == 3'(HDLC_STUFF_LEN));
  // One more payload 1 would complete a run; used to decide whether the
  // last byte still owes a stuffed zero before the closing flag.
  assign near_full = (ones_cnt == 3'(HDLC_STUFF_LEN - 1));

endmodule

// File: rtl/hdlc_tx_ctrl.sv
// HDLC transmit sequencer: flag, zero-inserted payload from the Tx buffer,
// closing flag or abort pattern, one bit per clock on a registered line.
module hdlc_tx_ctrl
  import hdlc_pkg::*;
#(
  parameter int BUF_DEPTH = 128,
  parameter int ADDR_W    = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tx_Enable,
  input  logic [7:0]        Tx_FrameSize,
  input  logic              Tx_AbortFrame,
  input  logic [7:0]        Tx_Data,
  output logic              Tx_RdBuff,
  output logic [ADDR_W-1:0] Tx_RdAddr,
  output logic              Tx,
  output logic              Tx_ValidFrame,
  output logic              Tx_AbortedTrans,
  output logic              Tx_Done
);

  localparam logic [8:0] DEPTH9 = 9'(BUF_DEPTH);

  tx_state_t         state, state_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        byte_idx, byte_idx_nxt;
  logic [7:0]        size_r;
  logic [7:0]        shreg, shreg_nxt;
  logic [7:0]        hold;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_addr;
  logic              done_pend;

  logic       tx_bit, bit_en, stuff_en, rd_en, accept;
  logic       size_ok, abort_ok, last_byte;
  logic [8:0] next_byte;
  logic       stall, near_full;

  assign size_ok   = (Tx_FrameSize != 8'd0) && ({1'b0, Tx_FrameSize} <= DEPTH9);
  assign abort_ok  = Tx_AbortFrame && ((state == START) || (state == DATA));
  assign next_byte = {1'b0, byte_idx} + 9'd1;
  assign last_byte = (byte_idx == size_r - 8'd1);

  hdlc_zero_insert u_zero_insert (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (state == START),
    .bit_en    (bit_en),
    .bit_val   (shreg[0]),
    .stuff_en  (stuff_en),
    .stall     (stall),
    .near_full (near_full)
  );

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    byte_idx_nxt = byte_idx;
    shreg_nxt    = shreg;
    tx_bit       = 1'b1;
    bit_en       = 1'b0;
    stuff_en     = 1'b0;
    rd_en        = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (Tx_Enable && size_ok) begin
          accept       = 1'b1;
          state_nxt    = START;
          bit_cnt_nxt  = 3'd0;
          byte_idx_nxt = 8'd0;
        end
      end
      START: begin
        tx_bit      = HDLC_FLAG[bit_cnt];
        rd_en       = (bit_cnt == 3'd0);
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          state_nxt = DATA;
          shreg_nxt = hold;
        end
      end
      DATA: begin
        if (stall) begin
          tx_bit   = 1'b0;
          stuff_en = 1'b1;
          // byte_idx == size_r only after the last byte has fully shifted
          if (byte_idx == size_r) state_nxt = END;
        end else begin
          tx_bit      = shreg[0];
          bit_en      = 1'b1;
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          rd_en       = (bit_cnt == 3'd0) && (next_byte < {1'b0, size_r});
          if (bit_cnt == 3'd7) begin
            byte_idx_nxt = byte_idx + 8'd1;
            shreg_nxt    = hold;
            if (last_byte && !(near_full && shreg[0])) state_nxt = END;
          end
        end
      end
      END: begin
        tx_bit      = HDLC_FLAG[bit_cnt];
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = IDLE;
      end
      ABORT: begin
        tx_bit      = HDLC_ABORT[bit_cnt];
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The bit computed this cycle still goes out; the abort pattern follows.
    if (abort_ok) begin
      state_nxt   = ABORT;
      bit_cnt_nxt = 3'd0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      byte_idx        <= '0;
      size_r          <= '0;
      shreg           <= '0;
      hold            <= '0;
      rd_vld          <= 1'b0;
      rd_addr         <= '0;
      done_pend       <= 1'b0;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Done         <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      shreg    <= shreg_nxt;
      if (accept) size_r <= Tx_FrameSize;
      if (accept) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + 1'b1;
      end
      rd_vld <= rd_en;
      if (rd_vld) hold <= Tx_Data;
      Tx              <= tx_bit;
      Tx_ValidFrame   <= (state != IDLE);
      Tx_AbortedTrans <= abort_ok;
      done_pend       <= (state == END) && (bit_cnt == 3'd7);
      Tx_Done         <= done_pend;
    end
  end

  assign Tx_RdBuff = rd_en;
  assign Tx_RdAddr = rd_addr;

endmodule
